// File: rtl/carregador_de_programa_if.sv
// carregador_de_programa_if: byte stream into the loader and instruction memory write port out of it.
interface carregador_de_programa_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    modport master (input byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_datain);
    modport slave (output byte_valid, byte_data, input byte_ready, mem_we, mem_addr, mem_datain);
endinterface

// File: rtl/carregador_de_programa.sv
// carregador_de_programa: loads a length-prefixed big-endian byte stream into instruction memory
// and keeps the CPU halted until a complete, valid image has been written.
module carregador_de_programa #(
    parameter int MEM_WORDS = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    carregador_de_programa_if.master        bus,
    output logic                            cpu_halt_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [15:0]                     words_loaded_o
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, CHECK, BYTE, WRITE, DONE, ERROR} state_t;
    state_t      state_q;
    logic [15:0] len_q, words_q, words_d;
    logic [1:0]  idx_q;
    logic [23:0] asm_q;
    logic [31:0] addr_q, data_q, word_d;
    logic        ready_q, we_q, halt_q, busy_q, done_q, error_q;
    logic        xfer;
    assign xfer    = bus.byte_valid && ready_q;
    assign words_d = words_q + 16'd1;
    assign word_d  = {asm_q, bus.byte_data};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            halt_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: if (start_i) begin
                    state_q <= LEN_HI;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b1;
                    halt_q  <= 1'b1;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    words_q <= '0;
                    addr_q  <= 32'(BASE_ADDR);
                end
                LEN_HI: if (xfer) begin
                    len_q[15:8] <= bus.byte_data;
                    state_q     <= LEN_LO;
                end
                LEN_LO: if (xfer) begin
                    len_q[7:0] <= bus.byte_data;
                    state_q    <= CHECK;
                    ready_q    <= 1'b0;
                end
                CHECK: if (len_q == 16'd0 || 32'(len_q) > 32'(MEM_WORDS)) begin
                    state_q <= ERROR;
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= BYTE;
                    idx_q   <= '0;
                    ready_q <= 1'b1;
                end
                BYTE: if (xfer) begin
                    asm_q <= word_d[23:0];
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q <= WRITE;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        data_q  <= word_d;
                    end
                end
                WRITE: begin
                    words_q <= words_d;
                    addr_q  <= addr_q + 32'd1;
                    if (words_d == len_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        halt_q  <= 1'b0;
                    end else begin
                        state_q <= BYTE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.byte_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_datain = data_q;
    assign cpu_halt_o     = halt_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;
endmodule

// File: doc/carregador_de_programa.md
Name: carregador_de_programa

Overview:
- Program loader and sequencer for the instruction memory's write port.
- Receives a length-prefixed byte stream from a byte source such as the UART receiver, and assembles big-endian 32-bit words.
- Issues one single-cycle write per word into instruction memory, starting at BASE_ADDR.
- Holds the CPU halted until a complete, valid image has been written.

Parameters:
- MEM_WORDS, 1024: instruction memory depth in words; upper bound for image length.
- BASE_ADDR, 0: word address of the first written instruction.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid and byte_ready are both 1.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  32  instruction memory word address.
- mem_datain  output  32  instruction word to write.
- cpu_halt  output  1  stalls the CPU or PC while the image is not valid.
- busy  output  1  a load is in progress.
- done  output  1  image loaded; sticky until the next start.
- error  output  1  bad length; sticky until the next start.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_datain=0.
  - cpu_halt=1, busy=0, done=0, error=0, words_loaded=0.
  - Internal length and byte counters clear.
  - Reset mid-load aborts immediately. Partially written memory is not cleared.
- States: IDLE, LEN_HI, LEN_LO, CHECK, BYTE, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR, on start:
  - Go to LEN_HI.
  - Clear done, error and words_loaded; set busy=1 and cpu_halt=1.
  - Load the address register with BASE_ADDR.
- LEN_HI:
  - byte_ready=1.
  - On transfer, length[15:8]=byte_data and go to LEN_LO.
- LEN_LO:
  - byte_ready=1.
  - On transfer, length[7:0]=byte_data and go to CHECK.
- CHECK (one cycle, byte_ready=0):
  - If length==0 or length>MEM_WORDS, go to ERROR.
  - Otherwise clear the byte index and go to BYTE.
- BYTE:
  - byte_ready=1.
  - Each transfer shifts into the assembly register, MSB first: the first byte becomes bits [31:24] and the fourth becomes bits [7:0].
  - The byte index counts 0..3. The transfer with index 3 goes to WRITE.
  - Gaps in byte_valid are allowed, with no timeout.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=current address, mem_datain=assembled word, byte_ready=0.
  - Next cycle: words_loaded+1 and address+1.
  - If words_loaded+1==length, go to DONE; otherwise go to BYTE.
- DONE:
  - done=1, busy=0, cpu_halt=0, byte_ready=0. Bytes arriving here are not accepted.
- ERROR:
  - error=1, busy=0, cpu_halt=1, byte_ready=0.
- mem_we is 0 in every state except WRITE.
- start is ignored in LEN_HI, LEN_LO, CHECK, BYTE and WRITE.
- start and a byte transfer in the same cycle while in IDLE: the byte is not consumed, because byte_ready=0 in IDLE.
- Timing:
  - Minimum load time = 2 + 1 + 5·length cycles after start, with back-to-back bytes.
  - Last mem_we to done=1 is 1 cycle.
- Address arithmetic is 32-bit with no wrap check needed, since length≤MEM_WORDS guarantees BASE_ADDR+length-1 is in range when BASE_ADDR=0.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles → cpu_halt=1, done=0, mem_we=0, byte_ready=0; release rst_n with no start → outputs unchanged.
- Basic load: start, then bytes 00 02 | 20 08 00 05 | AC 08 00 00, continuous valid → exactly two mem_we pulses: addr 0 data 0x20080005, then addr 1 data 0xAC080000; done=1 and cpu_halt=0 one cycle after the second write; words_loaded=2.
- Throttled source: same image with byte_valid toggling 1/0 each cycle → identical writes and final state; mem_we never asserted on a cycle with byte_ready=1.
- Bad length: start, bytes 00 00 → error=1, cpu_halt=1, no mem_we. Repeat with 04 01 (1025) → error=1.
- Max image: length 0x0400 with 1024 words where data=index → last write at addr 1023; done=1.
- Abort and restart: pull rst_n low after 3 of 5 words, then reload a 1-word image → single write to addr 0; done=1. A start pulse during BYTE is ignored, with no state change.
